sprite_compositor: RTL and testbench
====================================

Name:
sprite_compositor

Overview:
Pixel-pipeline stage between the VGA timing generator and the board VGA pins.
- Consumes the raw hcount/vcount/hsync/vsync/blank stream and drives the address port of a synchronous sprite memory (the manta image memory).
- Composites the returned 12-bit colour over a background colour, with colour-key transparency and power-of-two scaling.
- Outputs latency-matched, registered RGB and active-low syncs.
- Sprite position is double-buffered and updated only at frame boundaries, so the image never tears.

Parameters:
WIDTH, 128, sprite width in memory texels
HEIGHT, 128, sprite height in memory texels
SCALE_LOG2, 0, on-screen scale = 2**SCALE_LOG2 (0..3)
MEM_LATENCY, 2, cycles from mem_addr_out to valid mem_data_in (1..4)
KEY_COLOR, 12'hF0F, texel value treated as transparent
BG_COLOR, 12'h000, colour for non-sprite active pixels

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-high reset
hcount_in  in  11  horizontal pixel index
vcount_in  in  10  vertical line index
hsync_in  in  1  active-high hsync from timing generator
vsync_in  in  1  active-high vsync from timing generator
blank_in  in  1  high outside active video
pos_x_in  in  11  requested sprite left edge
pos_y_in  in  10  requested sprite top edge
pos_valid_in  in  1  one-cycle strobe: capture pos_x_in/pos_y_in as pending
pos_ack_out  out  1  one-cycle pulse when a pending position becomes active
mem_addr_out  out  $clog2(WIDTH*HEIGHT)  sprite memory read address
mem_data_in  in  12  sprite texel {r,g,b}, MEM_LATENCY cycles after address
vga_r, vga_g, vga_b  out  4 each  pixel colour
vga_hs, vga_vs  out  1 each  active-low syncs

Behaviour:
- Reset:
  - pipeline valid/sync/blank history cleared (blank history = 1)
  - active position = (0,0); pending flag = 0
  - pos_ack_out = 0; mem_addr_out = 0
  - vga_r/g/b = 0; vga_hs = vga_vs = 1
  - Reset mid-frame: outputs show blank until the delayed stream refills (4 cycles at default latency).
- Position double-buffer:
  - pos_valid_in loads the pending registers and sets pending. A later strobe overwrites pending (last-write-wins).
  - Frame boundary = rising edge of vsync_in, detected against a registered copy.
  - At the boundary, if pending: active <= pending, pending <= 0, pos_ack_out = 1 on the following cycle.
  - pos_valid_in on the same cycle as the boundary: the old pending value is applied now; the new value becomes pending for the next frame.
  - No pending at the boundary: no ack.
- Stage A (1 cycle), registered:
  - dx = {1'b0,hcount_in} - {1'b0,pos_x}; dy = {2'b0,vcount_in} - {1'b0,pos_y}, both 12-bit signed.
  - in_sprite = dx>=0 && dx<(WIDTH<<SCALE_LOG2) && dy>=0 && dy<(HEIGHT<<SCALE_LOG2).
  - mem_addr_out = (dy>>>SCALE_LOG2)*WIDTH + (dx>>>SCALE_LOG2) when in_sprite, else 0.
  - Sprite partly off the right/bottom edge is clipped. The 12-bit signed arithmetic must never wrap into a false hit.
- Stage B: in_sprite, blank, hsync, vsync are delayed MEM_LATENCY cycles to align with mem_data_in.
- Stage C (1 cycle), registered:
  - blank -> rgb 0
  - else in_sprite && mem_data_in != KEY_COLOR -> mem_data_in
  - else BG_COLOR
  - vga_hs = ~hsync_delayed; vga_vs = ~vsync_delayed
- Total latency from input timing to pins = MEM_LATENCY+2 cycles (4 at default). Syncs, blank and colour share the identical delay.
- Position changes never alter mem_addr_out mid-frame, except for the cycle sequence immediately after the vsync rising edge, which lies in blanking.

Test Plan:
- Reset, then free-run timing with pos (0,0): pixel (0,0) produces mem_addr_out=0 at cycle 1; a texel value of 12'h123 returned at cycle 3 appears on rgb at cycle 4; vga_hs/vga_vs equal inverted inputs delayed 4 cycles.
- pos (100,50), SCALE_LOG2=1: hcount=100,vcount=50 -> addr 0; hcount=101 -> addr 0; hcount=102 -> addr 1; vcount=52,hcount=100 -> addr 128; hcount=99 or hcount=356 -> in_sprite=0, BG on output.
- Texel equals 12'hF0F inside sprite -> BG_COLOR output; the same pixel during blank_in=1 -> rgb 0.
- pos_valid_in mid-frame with (200,200): active position unchanged until the vsync rise; pos_ack_out pulses exactly once, one cycle after the rise; the next frame is drawn at (200,200).
- pos_valid_in on the exact vsync-rise cycle with an older pending value: the older value is applied with an ack; the new value is applied and acked at the following frame.
- pos (1000,700), WIDTH=HEIGHT=128: hcount 1000..1023 are in-sprite and hcount 0..103 are not (no wrap); assert rst mid-line -> rgb 0, syncs 1 the next cycle, correct output resumes after 4 cycles.

Source files
------------

// File: rtl/sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module   : sprite_compositor
// Purpose  : Pixel-pipeline stage between the VGA timing generator and the
//            board pins. Addresses a synchronous sprite memory, composites the
//            returned texel over a background with colour-key transparency and
//            power-of-two scaling, and outputs latency-matched RGB and
//            active-low syncs. The sprite position is double-buffered and
//            swapped only on the vsync rising edge, so frames never tear.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_compositor #(
  parameter int          WIDTH       = 128,
  parameter int          HEIGHT      = 128,
  parameter int          SCALE_LOG2  = 0,
  parameter int          MEM_LATENCY = 2,
  parameter logic [11:0] KEY_COLOR   = 12'hF0F,
  parameter logic [11:0] BG_COLOR    = 12'h000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [10:0]                        hcount_in,
  input  logic [9:0]                         vcount_in,
  input  logic                               hsync_in,
  input  logic                               vsync_in,
  input  logic                               blank_in,
  input  logic [10:0]                        pos_x_in,
  input  logic [9:0]                         pos_y_in,
  input  logic                               pos_valid_in,
  output logic                               pos_ack_out,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]    mem_addr_out,
  input  logic [11:0]                        mem_data_in,
  output logic [3:0]                         vga_r,
  output logic [3:0]                         vga_g,
  output logic [3:0]                         vga_b,
  output logic                               vga_hs,
  output logic                               vga_vs
);

  localparam int          c_ADDR_W = $clog2(WIDTH*HEIGHT);
  // On-screen footprint of the sprite, in pixels.
  localparam logic [11:0] c_SPAN_X = 12'(WIDTH << SCALE_LOG2);
  localparam logic [11:0] c_SPAN_Y = 12'(HEIGHT << SCALE_LOG2);

  // --------------------------------------------------------------------------
  // Position double-buffer
  // --------------------------------------------------------------------------
  logic [10:0] r_act_x;
  logic [9:0]  r_act_y;
  logic [10:0] r_pend_x;
  logic [9:0]  r_pend_y;
  logic        r_pending;
  logic        r_vsync_q;
  logic        w_frame_edge;

  assign w_frame_edge = vsync_in & ~r_vsync_q;

  // Capture requested positions; promote pending to active at the frame edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync_q   <= 1'b0;
      r_pending   <= 1'b0;
      r_act_x     <= '0;
      r_act_y     <= '0;
      r_pend_x    <= '0;
      r_pend_y    <= '0;
      pos_ack_out <= 1'b0;
    end else begin
      r_vsync_q   <= vsync_in;
      pos_ack_out <= w_frame_edge & r_pending;
      // The old pending value is applied even if a new strobe lands now;
      // the new strobe then waits for the next frame.
      if (w_frame_edge && r_pending) begin
        r_act_x <= r_pend_x;
        r_act_y <= r_pend_y;
      end
      if (pos_valid_in) begin
        r_pend_x  <= pos_x_in;
        r_pend_y  <= pos_y_in;
        r_pending <= 1'b1;
      end else if (w_frame_edge) begin
        r_pending <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage A: hit test and address generation
  // --------------------------------------------------------------------------
  // Both operands are zero-extended to 12 bits, so the difference of two
  // 11-bit values can never overflow: bit 11 set means strictly negative.
  logic [11:0]         w_dx;
  logic [11:0]         w_dy;
  logic [11:0]         w_tx;
  logic [11:0]         w_ty;
  logic                w_in_sprite;
  logic [c_ADDR_W-1:0] w_addr;

  assign w_dx = {1'b0, hcount_in} - {1'b0, r_act_x};
  assign w_dy = {2'b0, vcount_in} - {2'b0, r_act_y};

  assign w_in_sprite = ~w_dx[11] && (w_dx < c_SPAN_X) &&
                       ~w_dy[11] && (w_dy < c_SPAN_Y);

  // Texel coordinates; only consumed when the offsets are known non-negative.
  assign w_tx = w_dx >> SCALE_LOG2;
  assign w_ty = w_dy >> SCALE_LOG2;

  assign w_addr = c_ADDR_W'(w_ty) * c_ADDR_W'(WIDTH) + c_ADDR_W'(w_tx);

  logic r_a_in;
  logic r_a_blank;
  logic r_a_hs;
  logic r_a_vs;

  // Register the memory address and the timing that travels with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_out <= '0;
      r_a_in       <= 1'b0;
      r_a_blank    <= 1'b1;
      r_a_hs       <= 1'b0;
      r_a_vs       <= 1'b0;
    end else begin
      mem_addr_out <= w_in_sprite ? w_addr : '0;
      r_a_in       <= w_in_sprite;
      r_a_blank    <= blank_in;
      r_a_hs       <= hsync_in;
      r_a_vs       <= vsync_in;
    end
  end

  // --------------------------------------------------------------------------
  // Stage B: delay timing by the memory read latency
  // --------------------------------------------------------------------------
  logic [MEM_LATENCY-1:0] r_b_in;
  logic [MEM_LATENCY-1:0] r_b_blank;
  logic [MEM_LATENCY-1:0] r_b_hs;
  logic [MEM_LATENCY-1:0] r_b_vs;

  // Shift chain aligning hit/blank/sync with the returning texel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_b_in    <= '0;
      r_b_blank <= '1;
      r_b_hs    <= '0;
      r_b_vs    <= '0;
    end else begin
      r_b_in[0]    <= r_a_in;
      r_b_blank[0] <= r_a_blank;
      r_b_hs[0]    <= r_a_hs;
      r_b_vs[0]    <= r_a_vs;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        r_b_in[i]    <= r_b_in[i-1];
        r_b_blank[i] <= r_b_blank[i-1];
        r_b_hs[i]    <= r_b_hs[i-1];
        r_b_vs[i]    <= r_b_vs[i-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage C: composite and drive the pins
  // --------------------------------------------------------------------------
  logic [11:0] w_rgb;

  // Blank wins, then an opaque sprite texel, otherwise the background.
  always_comb begin
    w_rgb = BG_COLOR;
    if (r_b_blank[MEM_LATENCY-1]) begin
      w_rgb = 12'h000;
    end else if (r_b_in[MEM_LATENCY-1] && (mem_data_in != KEY_COLOR)) begin
      w_rgb = mem_data_in;
    end
  end

  // Output registers; syncs are inverted to the board's active-low sense.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_r  <= 4'h0;
      vga_g  <= 4'h0;
      vga_b  <= 4'h0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else begin
      vga_r  <= w_rgb[11:8];
      vga_g  <= w_rgb[7:4];
      vga_b  <= w_rgb[3:0];
      vga_hs <= ~r_b_hs[MEM_LATENCY-1];
      vga_vs <= ~r_b_vs[MEM_LATENCY-1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_compositor
// Purpose  : Self-checking bench for sprite_compositor with a behavioural
//            model of position buffering, hit test, addressing and compositing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_compositor;

  localparam int          W   = 128;
  localparam int          H   = 128;
  localparam int          S   = 1;
  localparam int          L   = 2;
  localparam int          AW  = 14;
  localparam logic [11:0] KEY = 12'hF0F;
  localparam logic [11:0] BG  = 12'h5A3;

  logic          clk = 1'b0;
  logic          rst;
  logic [10:0]   hcount_in;
  logic [9:0]    vcount_in;
  logic          hsync_in, vsync_in, blank_in;
  logic [10:0]   pos_x_in;
  logic [9:0]    pos_y_in;
  logic          pos_valid_in;
  logic          pos_ack_out;
  logic [AW-1:0] mem_addr_out;
  logic [11:0]   mem_data_in;
  logic [3:0]    vga_r, vga_g, vga_b;
  logic          vga_hs, vga_vs;

  always #5 clk = ~clk;

  sprite_compositor #(
    .WIDTH(W), .HEIGHT(H), .SCALE_LOG2(S), .MEM_LATENCY(L),
    .KEY_COLOR(KEY), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
    .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .pos_valid_in(pos_valid_in),
    .pos_ack_out(pos_ack_out),
    .mem_addr_out(mem_addr_out), .mem_data_in(mem_data_in),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs)
  );

  // Sprite memory: synchronous read, L cycles from address to data.
  logic [11:0] mem_img [0:W*H-1];
  logic [11:0] mem_q   [0:L-1];
  always @(posedge clk) begin
    mem_q[0] <= mem_img[mem_addr_out];
    for (int i = 1; i < L; i++) mem_q[i] <= mem_q[i-1];
  end
  assign mem_data_in = mem_q[L-1];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model position state.
  int m_ax, m_ay, m_px, m_py;
  bit m_pend, m_vsq;

  // Expectations indexed by observation slot (posedge count mod 8).
  logic [13:0]   e_pix  [0:7];
  bit            e_pv   [0:7];
  logic [AW-1:0] e_addr [0:7];
  bit            e_ack  [0:7];
  bit            e_av   [0:7];

  logic [13:0]   cur_pix;
  bit            cur_pv;
  logic [AW:0]   cur_aa;
  bit            cur_av;

  // Drive one cycle of inputs, record what the model expects, advance.
  task automatic tick(input int h, input int v, input bit hs, input bit vs,
                      input bit bl, input bit pv, input int px, input int py,
                      input bit r);
    int dx, dy, a, idx;
    bit ins, fe;
    logic [11:0] tex, rgb;
    hcount_in = 11'(h); vcount_in = 10'(v);
    hsync_in = hs; vsync_in = vs; blank_in = bl;
    pos_valid_in = pv; pos_x_in = 11'(px); pos_y_in = 10'(py);
    rst = r;
    if (r) begin
      for (int k = 1; k <= 4; k++) begin
        e_pix[(cyc+k)%8] = {12'h000, 1'b1, 1'b1};
        e_pv[(cyc+k)%8]  = 1'b1;
      end
      e_addr[(cyc+1)%8] = '0; e_ack[(cyc+1)%8] = 1'b0; e_av[(cyc+1)%8] = 1'b1;
      m_ax = 0; m_ay = 0; m_pend = 1'b0; m_vsq = 1'b0;
    end else begin
      dx  = h - m_ax;
      dy  = v - m_ay;
      ins = (dx >= 0) && (dx < W * (1 << S)) && (dy >= 0) && (dy < H * (1 << S));
      a   = ins ? (dy / (1 << S)) * W + dx / (1 << S) : 0;
      tex = mem_img[a];
      if (bl)                     rgb = 12'h000;
      else if (ins && tex != KEY) rgb = tex;
      else                        rgb = BG;
      e_pix[(cyc+4)%8] = {rgb, ~hs, ~vs}; e_pv[(cyc+4)%8] = 1'b1;
      fe = vs && !m_vsq;
      e_addr[(cyc+1)%8] = AW'(a);
      e_ack[(cyc+1)%8]  = fe && m_pend;
      e_av[(cyc+1)%8]   = 1'b1;
      if (fe && m_pend) begin m_ax = m_px; m_ay = m_py; end
      if (pv) begin m_px = px; m_py = py; m_pend = 1'b1; end
      else if (fe) m_pend = 1'b0;
      m_vsq = vs;
    end
    @(negedge clk);
    cyc++;
    idx = cyc % 8;
    cur_pv = e_pv[idx]; cur_pix = e_pix[idx]; e_pv[idx] = 1'b0;
    cur_av = e_av[idx]; cur_aa = {e_addr[idx], e_ack[idx]}; e_av[idx] = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++)
      tick($urandom_range(0, 2047), $urandom_range(0, 1023), 1, 1, 0, 0, 0, 0, 1);
    checks++;
    if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, mem_addr_out, pos_ack_out} !==
        {12'h000, 1'b1, 1'b1, 14'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got rgb=%h hs=%b vs=%b addr=%h ack=%b exp rgb=000 hs=1 vs=1 addr=0 ack=0",
               {vga_r, vga_g, vga_b}, vga_hs, vga_vs, mem_addr_out, pos_ack_out);
    end
  endtask

  task automatic test_basic;
    tick(0, 0, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (mem_addr_out !== 14'd0) begin
      failures++; $display("FAIL basic_addr0 got=%h exp=0", mem_addr_out);
    end
    for (int i = 0; i < 43; i++) begin
      tick($urandom_range(0, 300), $urandom_range(0, 300), 1'($urandom), 0,
           1'($urandom_range(0, 3) == 0), 0, 0, 0, 0);
      if (i == 2) begin
        checks++;
        if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== {12'h123, 1'b0, 1'b1}) begin
          failures++;
          $display("FAIL basic_latency got=%h exp=%h", {vga_r, vga_g, vga_b, vga_hs, vga_vs},
                   {12'h123, 1'b0, 1'b1});
        end
      end
      if (cur_pv) begin
        checks++;
        if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== cur_pix) begin
          failures++;
          $display("FAIL basic_pix cyc=%0d got=%h exp=%h", cyc, {vga_r, vga_g, vga_b, vga_hs, vga_vs}, cur_pix);
        end
      end
      if (cur_av) begin
        checks++;
        if ({mem_addr_out, pos_ack_out} !== cur_aa) begin
          failures++;
          $display("FAIL basic_addr cyc=%0d got=%h exp=%h", cyc, {mem_addr_out, pos_ack_out}, cur_aa);
        end
      end
    end
  endtask

  task automatic test_scale;
    int th [6] = '{100, 101, 102, 100, 99, 356};
    int tv [6] = '{50, 50, 50, 52, 50, 50};
    int ta [6] = '{0, 0, 1, 128, 0, 0};
    tick(0, 0, 0, 0, 1, 1, 100, 50, 0);
    tick(0, 0, 0, 1, 1, 0, 0, 0, 0);
    checks++;
    if (pos_ack_out !== 1'b1) begin
      failures++; $display("FAIL scale_ack got=%b exp=1", pos_ack_out);
    end
    tick(0, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      if (i < 6) tick(th[i], tv[i], 0, 0, 0, 0, 0, 0, 0);
      else       tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (i < 6) begin
        checks++;
        if (mem_addr_out !== AW'(ta[i])) begin
          failures++;
          $display("FAIL scale_addr h=%0d v=%0d got=%0d exp=%0d", th[i], tv[i], mem_addr_out, ta[i]);
        end
      end
      if (cur_pv) begin
        checks++;
        if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== cur_pix) begin
          failures++;
          $display("FAIL scale_pix cyc=%0d got=%h exp=%h", cyc, {vga_r, vga_g, vga_b, vga_hs, vga_vs}, cur_pix);
        end
      end
      if (cur_av) begin
        checks++;
        if ({mem_addr_out, pos_ack_out} !== cur_aa) begin
          failures++;
          $display("FAIL scale_maddr cyc=%0d got=%h exp=%h", cyc, {mem_addr_out, pos_ack_out}, cur_aa);
        end
      end
    end
  endtask

  // Active position is (100,50), scale 2: texel 5 sits at (110,50).
  task automatic test_key;
    for (int pass = 0; pass < 2; pass++) begin
      tick(110, 50, 0, 0, 1'(pass), 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 1, 0, 0, 0, 0);
      checks++;
      if ({vga_r, vga_g, vga_b} !== (pass == 0 ? BG : 12'h000)) begin
        failures++;
        $display("FAIL key_pass%0d got=%h exp=%h", pass, {vga_r, vga_g, vga_b},
                 (pass == 0 ? BG : 12'h000));
      end
    end
  endtask

  task automatic test_pos_update;
    int acks;
    tick(0, 0, 0, 0, 1, 1, 200, 200, 0);
    for (int i = 0; i < 20; i++) begin
      tick(100 + $urandom_range(0, 300), 50 + $urandom_range(0, 300), 0, 0, 0, 0, 0, 0, 0);
      if (cur_pv) begin
        checks++;
        if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== cur_pix) begin
          failures++;
          $display("FAIL posupd_pix cyc=%0d got=%h exp=%h", cyc, {vga_r, vga_g, vga_b, vga_hs, vga_vs}, cur_pix);
        end
      end
      if (cur_av) begin
        checks++;
        if ({mem_addr_out, pos_ack_out} !== cur_aa) begin
          failures++;
          $display("FAIL posupd_addr cyc=%0d got=%h exp=%h", cyc, {mem_addr_out, pos_ack_out}, cur_aa);
        end
      end
    end
    tick(102, 50, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (mem_addr_out !== 14'd1) begin
      failures++; $display("FAIL posupd_old got=%0d exp=1", mem_addr_out);
    end
    tick(0, 0, 0, 1, 1, 0, 0, 0, 0);
    checks++;
    if (pos_ack_out !== 1'b1) begin
      failures++; $display("FAIL posupd_ack got=%b exp=1", pos_ack_out);
    end
    acks = int'(pos_ack_out);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, (i < 2) ? 1'b1 : 1'b0, 1, 0, 0, 0, 0);
      acks += int'(pos_ack_out);
    end
    checks++;
    if (acks !== 1) begin
      failures++; $display("FAIL posupd_ackcount got=%0d exp=1", acks);
    end
    tick(202, 200, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (mem_addr_out !== 14'd1) begin
      failures++; $display("FAIL posupd_new got=%0d exp=1", mem_addr_out);
    end
  endtask

  task automatic test_boundary_strobe;
    tick(0, 0, 0, 0, 1, 1, 300, 100, 0);
    tick(0, 0, 0, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 1, 1, 400, 150, 0);
    checks++;
    if (pos_ack_out !== 1'b1) begin
      failures++; $display("FAIL bnd_ack1 got=%b exp=1", pos_ack_out);
    end
    tick(0, 0, 0, 1, 1, 0, 0, 0, 0);
    tick(302, 100, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (mem_addr_out !== 14'd1) begin
      failures++; $display("FAIL bnd_old_applied got=%0d exp=1", mem_addr_out);
    end
    tick(402, 150, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (mem_addr_out !== 14'd3251) begin
      failures++; $display("FAIL bnd_new_pending got=%0d exp=3251", mem_addr_out);
    end
    tick(0, 0, 0, 1, 1, 0, 0, 0, 0);
    checks++;
    if (pos_ack_out !== 1'b1) begin
      failures++; $display("FAIL bnd_ack2 got=%b exp=1", pos_ack_out);
    end
    tick(402, 150, 0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (mem_addr_out !== 14'd1) begin
      failures++; $display("FAIL bnd_new_applied got=%0d exp=1", mem_addr_out);
    end
    tick(0, 0, 0, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 1, 0, 0, 0, 0);
    checks++;
    if (pos_ack_out !== 1'b0) begin
      failures++; $display("FAIL bnd_no_pending_ack got=%b exp=0", pos_ack_out);
    end
  endtask

  task automatic test_edge_wrap;
    int h;
    tick(0, 0, 0, 0, 1, 1, 1000, 700, 0);
    tick(0, 0, 0, 1, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 136; i++) begin
      h = (i < 24) ? 1000 + i : i - 24;
      if (i < 128) tick(h, 700, 1, 0, 0, 0, 0, 0, 0);
      else         tick(h, 700, 1, 0, 0, 0, 0, 0, (i == 130));
      if (i < 24) begin
        checks++;
        if (mem_addr_out !== AW'(i / 2)) begin
          failures++; $display("FAIL wrap_in h=%0d got=%0d exp=%0d", h, mem_addr_out, i / 2);
        end
      end
      if (i == 130) begin
        checks++;
        if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== {12'h000, 1'b1, 1'b1}) begin
          failures++;
          $display("FAIL wrap_rst got=%h exp=%h", {vga_r, vga_g, vga_b, vga_hs, vga_vs}, {12'h000, 1'b1, 1'b1});
        end
      end
      if (cur_pv) begin
        checks++;
        if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== cur_pix) begin
          failures++;
          $display("FAIL wrap_pix cyc=%0d got=%h exp=%h", cyc, {vga_r, vga_g, vga_b, vga_hs, vga_vs}, cur_pix);
        end
      end
      if (cur_av) begin
        checks++;
        if ({mem_addr_out, pos_ack_out} !== cur_aa) begin
          failures++;
          $display("FAIL wrap_addr cyc=%0d got=%h exp=%h", cyc, {mem_addr_out, pos_ack_out}, cur_aa);
        end
      end
    end
  endtask

  task automatic test_random;
    int h, v, px, py;
    bit vs, pv;
    vs = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        h = m_ax + $urandom_range(0, 300) - 20;
        v = m_ay + $urandom_range(0, 300) - 20;
        if (h < 0) h = 0; if (h > 2047) h = 2047;
        if (v < 0) v = 0; if (v > 1023) v = 1023;
      end else begin
        h = $urandom_range(0, 2047);
        v = $urandom_range(0, 1023);
      end
      if ($urandom_range(0, 39) == 0) vs = ~vs;
      pv = ($urandom_range(0, 49) == 0);
      px = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 300) : $urandom_range(0, 2047);
      py = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 300) : $urandom_range(0, 1023);
      tick(h, v, 1'($urandom), vs, 1'($urandom_range(0, 3) == 0), pv, px, py,
           ($urandom_range(0, 999) == 0));
      if (cur_pv) begin
        checks++;
        if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== cur_pix) begin
          failures++;
          $display("FAIL rand_pix cyc=%0d got=%h exp=%h", cyc, {vga_r, vga_g, vga_b, vga_hs, vga_vs}, cur_pix);
        end
      end
      if (cur_av) begin
        checks++;
        if ({mem_addr_out, pos_ack_out} !== cur_aa) begin
          failures++;
          $display("FAIL rand_addr cyc=%0d got=%h exp=%h", cyc, {mem_addr_out, pos_ack_out}, cur_aa);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < W*H; i++)
      mem_img[i] = ($urandom_range(0, 7) == 0) ? KEY : 12'($urandom);
    mem_img[0] = 12'h123;
    mem_img[5] = KEY;
    for (int i = 0; i < 8; i++) begin e_pv[i] = 1'b0; e_av[i] = 1'b0; end
    m_ax = 0; m_ay = 0; m_px = 0; m_py = 0; m_pend = 1'b0; m_vsq = 1'b0;
    rst = 1'b1; hcount_in = '0; vcount_in = '0; hsync_in = 1'b0; vsync_in = 1'b0;
    blank_in = 1'b1; pos_x_in = '0; pos_y_in = '0; pos_valid_in = 1'b0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_scale;
    test_key;
    test_pos_update;
    test_boundary_strobe;
    test_edge_wrap;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
